// File: rtl/beat_sequencer_if.sv
// Command and beat-output bundle between the player control and the beat sequencer.
interface beat_sequencer_if #(
  parameter int STEPS    = 16,
  parameter int PERIOD_W = 28
);
  localparam int STEP_W = $clog2(STEPS);

  logic                start;
  logic                pause;
  logic                stop;
  logic                loop_en;
  logic [PERIOD_W-1:0] step_period;
  logic [STEPS-1:0]    pattern;
  logic [STEP_W-1:0]   step;
  logic                step_tick;
  logic                play;
  logic                running;
  logic                done;

  modport master (
    output start, pause, stop, loop_en, step_period, pattern,
    input  step, step_tick, play, running, done
  );

  modport slave (
    input  start, pause, stop, loop_en, step_period, pattern,
    output step, step_tick, play, running, done
  );
endinterface

// File: rtl/beat_sequencer.sv
// 16-step beat sequencer: programmable step period, start/pause/stop control,
// pattern-indexed play gate. Every output is registered from next-state values.
module beat_sequencer #(
  parameter int STEPS    = 16,
  parameter int PERIOD_W = 28,
  parameter int MIN_PER  = 2
) (
  input  logic             clock,
  input  logic             reset,
  beat_sequencer_if.slave  bus
);
  localparam int STEP_W = $clog2(STEPS);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t              state, state_nxt;
  logic [PERIOD_W-1:0] cnt, cnt_nxt, per_q, per_nxt, per_in;
  logic [STEP_W-1:0]   step_nxt;
  logic                tick_nxt, done_nxt, play_nxt, running_nxt;
  logic                boundary, last;

  // Requested period clamped to the shortest supported step.
  assign per_in   = (bus.step_period < PERIOD_W'(MIN_PER)) ? PERIOD_W'(MIN_PER) : bus.step_period;
  assign boundary = (state == RUN) && (cnt == per_q - PERIOD_W'(1));
  assign last     = (bus.step == STEP_W'(STEPS - 1));

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: stop beats pause beats start; a finished one-shot bar beats pause.
  always_comb begin
    state_nxt = state;
    if (bus.stop) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (bus.start) state_nxt = RUN;
        RUN:     if (boundary && last && !bus.loop_en) state_nxt = IDLE;
                 else if (bus.pause) state_nxt = PAUSE;
        PAUSE:   if (!bus.pause && bus.start) state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Datapath and output next values. Pausing at a boundary still advances the
  // step but drops its tick, since resume never emits one.
  always_comb begin
    cnt_nxt  = cnt;
    step_nxt = bus.step;
    per_nxt  = per_q;
    tick_nxt = 1'b0;
    done_nxt = 1'b0;
    if (bus.stop) begin
      cnt_nxt  = '0;
      step_nxt = '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          cnt_nxt  = '0;
          step_nxt = '0;
          per_nxt  = per_in;
          tick_nxt = 1'b1;
        end
        RUN: if (boundary) begin
          cnt_nxt = '0;
          per_nxt = per_in;
          if (last && !bus.loop_en) begin
            step_nxt = '0;
            done_nxt = 1'b1;
          end else begin
            step_nxt = last ? '0 : bus.step + STEP_W'(1);
            tick_nxt = !bus.pause;
          end
        end else begin
          cnt_nxt = cnt + PERIOD_W'(1);
        end
        default: ;
      endcase
    end
    running_nxt = (state_nxt == RUN);
    play_nxt    = running_nxt && bus.pattern[step_nxt] && (cnt_nxt < (per_nxt >> 1));
  end

  // Output and datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt           <= '0;
      per_q         <= PERIOD_W'(MIN_PER);
      bus.step      <= '0;
      bus.step_tick <= 1'b0;
      bus.play      <= 1'b0;
      bus.running   <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      cnt           <= cnt_nxt;
      per_q         <= per_nxt;
      bus.step      <= step_nxt;
      bus.step_tick <= tick_nxt;
      bus.play      <= play_nxt;
      bus.running   <= running_nxt;
      bus.done      <= done_nxt;
    end
  end
endmodule

// File: tb/tb_beat_sequencer.sv
// Bench for beat_sequencer: directed scenarios then random commands, all
// scored against a cycles-left reference model through an expectation queue.
module tb_beat_sequencer;
  logic clock = 1'b0;
  logic reset = 1'b0;

  beat_sequencer_if #(.STEPS(16), .PERIOD_W(28)) bus ();

  beat_sequencer #(.STEPS(16), .PERIOD_W(28), .MIN_PER(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    int step;
    bit tick;
    bit done;
    bit run;
    bit play;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: mode 0 idle, 1 run, 2 pause; a step lasts m_len cycles,
  // m_left counts the cycles of the current step still to come (incl. this one).
  int m_mode = 0, m_pos = 0, m_len = 2, m_left = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int clamp(input int p);
    return (p < 2) ? 2 : p;
  endfunction

  // Predict the outputs after the next clock edge from the inputs now applied.
  task automatic model_step();
    exp_t e;
    bit   tk = 0, dn = 0;
    if (!reset) begin
      m_mode = 0; m_pos = 0; m_len = 2; m_left = 0;
    end else if (bus.stop) begin
      m_mode = 0; m_pos = 0;
    end else if (m_mode == 0) begin
      if (bus.start) begin
        m_mode = 1; m_pos = 0; m_len = clamp(int'(bus.step_period)); m_left = m_len; tk = 1;
      end
    end else if (m_mode == 1) begin
      if (m_left == 1) begin
        m_len = clamp(int'(bus.step_period)); m_left = m_len;
        if (m_pos == 15 && !bus.loop_en) begin
          m_mode = 0; m_pos = 0; dn = 1;
        end else begin
          m_pos = (m_pos + 1) % 16;
          tk = !bus.pause;
          if (bus.pause) m_mode = 2;
        end
      end else begin
        m_left--;
        if (bus.pause) m_mode = 2;
      end
    end else if (!bus.pause && bus.start) begin
      m_mode = 1;
    end
    e.step = m_pos;
    e.tick = tk;
    e.done = dn;
    e.run  = (m_mode == 1);
    e.play = (m_mode == 1) && bus.pattern[m_pos] && ((m_len - m_left) < m_len / 2);
    exp_q.push_back(e);
  endtask

  // Monitor: one expectation per sampled cycle, compared away from the edge.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("step",      int'(bus.step),      e.step);
      chk("step_tick", int'(bus.step_tick), int'(e.tick));
      chk("done",      int'(bus.done),      int'(e.done));
      chk("running",   int'(bus.running),   int'(e.run));
      chk("play",      int'(bus.play),      int'(e.play));
    end
  end

  task automatic cyc(input int n = 1);
    for (int i = 0; i < n; i++) begin
      model_step();
      @(negedge clock); #1;
      bus.start = 1'b0; bus.pause = 1'b0; bus.stop = 1'b0;
    end
  endtask

  task automatic go(input int per, input bit lp, input logic [15:0] pat);
    bus.step_period = 28'(per); bus.loop_en = lp; bus.pattern = pat;
    bus.start = 1'b1;
    cyc();
  endtask

  initial begin
    bus.start = 0; bus.pause = 0; bus.stop = 0; bus.loop_en = 0;
    bus.step_period = 28'd4; bus.pattern = 16'h0005;
    @(negedge clock); #1;
    cyc(3);
    reset = 1'b1;
    cyc(2);

    // Single bar, period 4, pattern 0x0005, then idle past the done pulse.
    go(4, 0, 16'h0005);
    cyc(70);

    // Loop across the bar wrap, 40+ steps.
    go(4, 1, 16'hA5C3);
    cyc(170);
    bus.stop = 1'b1;
    cyc(3);

    // Pause in step 3 at cnt=1, hold 10 cycles, resume.
    go(4, 1, 16'h00FF);
    cyc(13);
    bus.pause = 1'b1;
    cyc(11);
    bus.start = 1'b1;
    cyc(12);
    bus.stop = 1'b1;
    cyc(2);

    // Clamp: period 0 gives 2-cycle steps.
    go(0, 1, 16'hFFFF);
    cyc(12);
    bus.stop = 1'b1;
    cyc(2);

    // Tempo change 4->8 during step 2.
    go(4, 1, 16'h000C);
    cyc(9);
    bus.step_period = 28'd8;
    cyc(25);

    // Priority: all three while running, then start+pause from idle.
    bus.stop = 1; bus.pause = 1; bus.start = 1;
    cyc(3);
    bus.pause = 1; bus.start = 1;
    cyc(8);

    // Reset mid-bar: outputs clear at once and stay clear while held.
    reset = 1'b0;
    #1;
    chk("rst_running", int'(bus.running), 0);
    chk("rst_step",    int'(bus.step),    0);
    chk("rst_play",    int'(bus.play),    0);
    cyc(3);
    reset = 1'b1;
    cyc(2);

    // Random commands, periods and patterns.
    for (int i = 0; i < 4000; i++) begin
      bus.start = ($urandom_range(0, 11) == 0);
      bus.pause = ($urandom_range(0, 31) == 0);
      bus.stop  = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 63) == 0) bus.loop_en = ~bus.loop_en;
      if ($urandom_range(0, 15) == 0) bus.step_period = 28'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0)  bus.pattern = 16'($urandom);
      if ($urandom_range(0, 999) == 0) reset = 1'b0;
      else if (!reset && $urandom_range(0, 2) == 0) reset = 1'b1;
      cyc();
    end
    reset = 1'b1;
    cyc(2);

    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
